// File: rtl/booth_pp_pkg.sv
// Shared constants, Booth digit type and radix-4 recoding for booth_pp_gen.
package booth_pp_pkg;

  localparam int IN_W   = 8;
  localparam int PP_W   = 16;
  localparam int NUM_PP = 5;

  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_digit_t;

  // Triplet is {b[2i+1], b[2i], b[2i-1]}; zero digit keeps every bit clear.
  function automatic booth_digit_t booth_recode(input logic [2:0] trip);
    booth_digit_t d;
    d = '0;
    case (trip)
      3'b001, 3'b010: d.one = 1'b1;
      3'b011:         d.two = 1'b1;
      3'b100:         begin d.neg = 1'b1; d.two = 1'b1; end
      3'b101, 3'b110: begin d.neg = 1'b1; d.one = 1'b1; end
      default:        d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_pp_row.sv
// One Booth partial-product row: (digit * a_ext) << 2*row, truncated to PP_W.
module booth_pp_row
  import booth_pp_pkg::*;
(
  input  logic [PP_W-1:0] a_ext,
  input  booth_digit_t    digit,
  input  logic [2:0]      row,
  output logic [PP_W-1:0] pp
);

  logic [PP_W-1:0] mag;
  logic [PP_W-1:0] val;

  always_comb begin
    mag = '0;
    if (digit.one)
      mag = a_ext;
    else if (digit.two)
      mag = a_ext << 1;
    // Full two's-complement negation here so no hot-one row is needed downstream.
    val = digit.neg ? (~mag + PP_W'(1)) : mag;
    pp  = val << {row, 1'b0};
  end

endmodule

// File: rtl/booth_pp_gen.sv
// Two-stage radix-4 Booth partial-product generator feeding a 5-input wallaceTree.
// Optional output-handshake counter on io_perf_ops: define BOOTH_PP_GEN_PERF_CNT_EN.
module booth_pp_gen #(
  parameter int IN_W  = 8,
  parameter int CNT_W = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          io_in_valid,
  output logic                          io_in_ready,
  input  logic [IN_W-1:0]               io_in_a,
  input  logic [IN_W-1:0]               io_in_b,
  input  logic                          io_in_signed,
  output logic                          io_out_valid,
  input  logic                          io_out_ready,
  output logic [booth_pp_pkg::PP_W-1:0] io_out_pp_0,
  output logic [booth_pp_pkg::PP_W-1:0] io_out_pp_1,
  output logic [booth_pp_pkg::PP_W-1:0] io_out_pp_2,
  output logic [booth_pp_pkg::PP_W-1:0] io_out_pp_3,
  output logic [booth_pp_pkg::PP_W-1:0] io_out_pp_4
`ifdef BOOTH_PP_GEN_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]              io_perf_ops
`endif
);

  import booth_pp_pkg::*;

  if (IN_W != 8) begin : g_bad_in_w
    $error("booth_pp_gen: only IN_W = 8 is supported");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("booth_pp_gen: CNT_W must be at least 1");
  end

  logic                          s1_valid;
  logic                          s2_valid;
  logic                          s2_advance;
  logic [IN_W-1:0]               s1_a;
  logic                          s1_signed;
  booth_digit_t [NUM_PP-1:0]     s1_digit;
  booth_digit_t [NUM_PP-1:0]     in_digit;
  logic [2*NUM_PP-1:0]           b_ext;
  logic [2*NUM_PP:0]             b_trip;
  logic [PP_W-1:0]               a_ext;
  logic [PP_W-1:0]               row_pp [NUM_PP];
  logic [PP_W-1:0]               s2_pp  [NUM_PP];

  assign s2_advance  = !s2_valid || io_out_ready;
  assign io_in_ready = !s1_valid || s2_advance;

  // Multiplier extended to 10 bits with an implicit b[-1] = 0 below bit 0.
  assign b_ext  = {{(2*NUM_PP-IN_W){io_in_signed & io_in_b[IN_W-1]}}, io_in_b};
  assign b_trip = {b_ext, 1'b0};

  always_comb begin
    in_digit = '0;
    for (int i = 0; i < NUM_PP; i++)
      in_digit[i] = booth_recode(b_trip[2*i +: 3]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_signed <= 1'b0;
      s1_digit  <= '0;
    end else if (io_in_ready) begin
      s1_valid <= io_in_valid;
      if (io_in_valid) begin
        s1_a      <= io_in_a;
        s1_signed <= io_in_signed;
        s1_digit  <= in_digit;
      end
    end
  end

  assign a_ext = {{(PP_W-IN_W){s1_signed & s1_a[IN_W-1]}}, s1_a};

  for (genvar g = 0; g < NUM_PP; g++) begin : g_row
    booth_pp_row u_row (
      .a_ext (a_ext),
      .digit (s1_digit[g]),
      .row   (3'(g)),
      .pp    (row_pp[g])
    );
  end

  // S2 only reloads on advance, so a stalled beat stays put until taken.
  always_ff @(posedge clock) begin
    if (reset) begin
      s2_valid <= 1'b0;
      for (int i = 0; i < NUM_PP; i++)
        s2_pp[i] <= '0;
    end else if (s2_advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        for (int i = 0; i < NUM_PP; i++)
          s2_pp[i] <= row_pp[i];
      end
    end
  end

  assign io_out_valid = s2_valid;
  assign io_out_pp_0  = s2_pp[0];
  assign io_out_pp_1  = s2_pp[1];
  assign io_out_pp_2  = s2_pp[2];
  assign io_out_pp_3  = s2_pp[3];
  assign io_out_pp_4  = s2_pp[4];

`ifdef BOOTH_PP_GEN_PERF_CNT_EN
  always_ff @(posedge clock) begin
    if (reset)
      io_perf_ops <= '0;
    else if (io_out_valid && io_out_ready)
      io_perf_ops <= io_perf_ops + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_booth_pp_gen.sv
// Randomised self-checking bench for booth_pp_gen with an arithmetic Booth reference model.
// Honours BOOTH_PP_GEN_PERF_CNT_EN to also check io_perf_ops.
module tb_booth_pp_gen;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        io_in_valid = 1'b0;
  logic        io_in_ready;
  logic [7:0]  io_in_a = '0;
  logic [7:0]  io_in_b = '0;
  logic        io_in_signed = 1'b0;
  logic        io_out_valid;
  logic        io_out_ready = 1'b0;
  logic [15:0] pp [5];
`ifdef BOOTH_PP_GEN_PERF_CNT_EN
  logic [31:0] io_perf_ops;
`endif

  booth_pp_gen #(.IN_W(8), .CNT_W(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_in_a      (io_in_a),
    .io_in_b      (io_in_b),
    .io_in_signed (io_in_signed),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_out_pp_0  (pp[0]),
    .io_out_pp_1  (pp[1]),
    .io_out_pp_2  (pp[2]),
    .io_out_pp_3  (pp[3]),
    .io_out_pp_4  (pp[4])
`ifdef BOOTH_PP_GEN_PERF_CNT_EN
    ,
    .io_perf_ops  (io_perf_ops)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sgn;
  } beat_t;

  beat_t       pending [$];
  beat_t       inflight [$];
  int          tests_run  = 0;
  int          fail_count = 0;
  int          hs_count   = 0;
  int          accepted   = 0;
  bit          stalled    = 0;
  bit          in_shown   = 0;
  logic [15:0] held_pp [5];
  logic [15:0] last_pp [5];
  logic [15:0] last_sum = '0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Multiplier bit k of the extended operand, with b[-1] = 0.
  function automatic int bbit(beat_t bt, int k);
    if (k < 0) return 0;
    if (k > 7) return bt.sgn ? int'(bt.b[7]) : 0;
    return int'(bt.b[k]);
  endfunction

  function automatic int opval(logic [7:0] v, logic sgn);
    return sgn ? int'($signed(v)) : int'(v);
  endfunction

  function automatic logic [15:0] model_pp(beat_t bt, int i);
    int d;
    d = bbit(bt, 2*i-1) + bbit(bt, 2*i) - 2*bbit(bt, 2*i+1);
    return 16'(d * opval(bt.a, bt.sgn) * (1 << (2*i)));
  endfunction

  function automatic logic [15:0] model_prod(beat_t bt);
    return 16'(opval(bt.a, bt.sgn) * opval(bt.b, bt.sgn));
  endfunction

  // One cycle: drive at negedge, then evaluate the handshakes the coming posedge will take.
  task automatic applyStimulus(input bit drive_valid, input bit out_rdy);
    beat_t       exp;
    logic [15:0] sum;
    @(negedge clock);
    if (pending.size() > 0 && (drive_valid || in_shown) && !reset) begin
      io_in_valid  = 1'b1;
      io_in_a      = pending[0].a;
      io_in_b      = pending[0].b;
      io_in_signed = pending[0].sgn;
    end else begin
      io_in_valid = 1'b0;
    end
    io_out_ready = out_rdy;
    #1;
    if (reset) begin
      stalled  = 0;
      in_shown = 0;
    end else begin
      if (stalled) begin
        checkOutput("hold_valid", 32'(io_out_valid), 32'd1);
        for (int i = 0; i < 5; i++)
          checkOutput("hold_pp", 32'(pp[i]), 32'(held_pp[i]));
      end
      if (io_out_valid && io_out_ready) begin
        if (inflight.size() == 0) begin
          checkOutput("spurious_out", 32'(io_out_valid), 32'd0);
        end else begin
          exp = inflight.pop_front();
          sum = '0;
          for (int i = 0; i < 5; i++) begin
            checkOutput("pp_row", 32'(pp[i]), 32'(model_pp(exp, i)));
            sum += pp[i];
            last_pp[i] = pp[i];
          end
          if (exp.sgn)
            checkOutput("pp4_signed_zero", 32'(pp[4]), 32'd0);
          checkOutput("pp_sum", 32'(sum), 32'(model_prod(exp)));
          last_sum = sum;
        end
        hs_count++;
      end
      stalled = io_out_valid && !io_out_ready;
      for (int i = 0; i < 5; i++)
        held_pp[i] = pp[i];
      if (io_in_valid && io_in_ready) begin
        inflight.push_back(pending.pop_front());
        accepted++;
        in_shown = 0;
      end else begin
        in_shown = io_in_valid;
      end
    end
  endtask

  task automatic drain(input int budget);
    for (int c = 0; c < budget && (pending.size() + inflight.size()) > 0; c++)
      applyStimulus(1, 1);
    checkOutput("drain", 32'(pending.size() + inflight.size()), 32'd0);
  endtask

  task automatic runBeat(input logic [7:0] a, input logic [7:0] b, input logic sgn);
    pending.push_back('{a: a, b: b, sgn: sgn});
    drain(20);
  endtask

  initial begin
    beat_t bt;
    repeat (3) applyStimulus(0, 0);
    checkOutput("rst_valid", 32'(io_out_valid), 32'd0);
    for (int i = 0; i < 5; i++)
      checkOutput("rst_pp", 32'(pp[i]), 32'd0);
`ifdef BOOTH_PP_GEN_PERF_CNT_EN
    checkOutput("rst_perf", io_perf_ops, 32'd0);
`endif
    reset = 1'b0;
    applyStimulus(0, 1);
    checkOutput("rst_in_ready", 32'(io_in_ready), 32'd1);

    pending.push_back('{a: 8'd3, b: 8'd2, sgn: 1'b0});
    applyStimulus(1, 1);
    applyStimulus(0, 1);
    checkOutput("latency_t1", 32'(io_out_valid), 32'd0);
    applyStimulus(0, 1);
    checkOutput("latency_t2", 32'(io_out_valid), 32'd1);
    checkOutput("pp0_3x2", 32'(last_pp[0]), 32'h0000_FFFA);
    checkOutput("pp1_3x2", 32'(last_pp[1]), 32'h0000_000C);
    for (int i = 2; i < 5; i++)
      checkOutput("ppx_3x2", 32'(last_pp[i]), 32'd0);
    checkOutput("sum_3x2", 32'(last_sum), 32'h0006);

    runBeat(8'd255, 8'd255, 1'b0);
    checkOutput("sum_255x255", 32'(last_sum), 32'hFE01);
    runBeat(8'h80, 8'h80, 1'b1);
    checkOutput("sum_m128sq", 32'(last_sum), 32'h4000);
    checkOutput("pp4_m128sq", 32'(last_pp[4]), 32'd0);
    runBeat(8'hFF, 8'h01, 1'b1);
    checkOutput("sum_m1x1", 32'(last_sum), 32'hFFFF);
    checkOutput("pp4_m1x1", 32'(last_pp[4]), 32'd0);

    // Four back-to-back beats against a blocked output.
    accepted = 0;
    for (int n = 0; n < 4; n++) begin
      bt.a = 8'($urandom); bt.b = 8'($urandom); bt.sgn = 1'($urandom);
      pending.push_back(bt);
    end
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1, 0);
      if (c == 2)
        checkOutput("stall_in_ready", 32'(io_in_ready), 32'd0);
    end
    checkOutput("stall_accepted", 32'(accepted), 32'd2);
    drain(30);

    // Reset with two beats in flight.
    for (int n = 0; n < 2; n++)
      pending.push_back('{a: 8'(n + 1), b: 8'(n + 5), sgn: 1'b0});
    applyStimulus(1, 0);
    applyStimulus(1, 0);
    reset = 1'b1;
    applyStimulus(0, 0);
    reset = 1'b0;
    inflight.delete();
    pending.delete();
    hs_count = 0;
    checkOutput("midrst_valid", 32'(io_out_valid), 32'd0);
    checkOutput("midrst_in_ready", 32'(io_in_ready), 32'd1);
    for (int i = 0; i < 5; i++)
      checkOutput("midrst_pp", 32'(pp[i]), 32'd0);
`ifdef BOOTH_PP_GEN_PERF_CNT_EN
    checkOutput("midrst_perf", io_perf_ops, 32'd0);
`endif
    applyStimulus(0, 1);
    checkOutput("postrst_valid", 32'(io_out_valid), 32'd0);
    runBeat(8'd7, 8'd9, 1'b0);
    checkOutput("sum_7x9", 32'(last_sum), 32'h003F);

    // Random traffic with random backpressure.
    for (int n = 0; n < 10000; n++) begin
      bt.a = 8'($urandom); bt.b = 8'($urandom); bt.sgn = 1'($urandom);
      pending.push_back(bt);
    end
    for (int c = 0; c < 60000 && pending.size() > 0; c++)
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    drain(100);
    applyStimulus(0, 0);
`ifdef BOOTH_PP_GEN_PERF_CNT_EN
    checkOutput("perf_ops", io_perf_ops, 32'(hs_count));
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
